mem_wb_ctl: RTL and testbench
=============================

MEM_WB_CTL -- requirements
Module: mem_wb_ctl

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 instr_acc  in  32  instruction word handed over by the execute control stage.
REQ-004 acc_valid  in  1  instr_acc holds a real instruction, not a bubble.
REQ-005 stall  out  1  freeze upstream stages; instr_acc is not consumed while high.
REQ-006 mem_req  out  1  data-memory request, held until accepted.
REQ-007 MemRW  out  1  1 = store, 0 = load; valid while mem_req is high.
REQ-008 mem_size  out  2  funct3[1:0] of the access: 0 byte, 1 half, 2 word.
REQ-009 load_unsigned  out  1  funct3[2] of a load, for the zero-extend select.
REQ-010 mem_ack  in  1  memory accepts or completes the current request this cycle.
REQ-011 RegWEn  out  1  register-file write enable, WB stage.
REQ-012 WBSel  out  2  writeback source: 0 memory data, 1 ALU, 2 PC+4.
REQ-013 rd_wb  out  5  destination register, WB stage.
REQ-014 stall_cnt  out  16  saturating count of cycles with stall high.

Function
REQ-015 The block SHALL hold two pipeline registers, ACC and WB, each storing {valid, instr[31:0]}.
REQ-016 When stall is low, ACC SHALL load {acc_valid, instr_acc} on each edge.
REQ-017 When stall is high, ACC SHALL hold its contents.
REQ-018 Opcode classes SHALL be: LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, OP 0110011, OP-IMM 0010011; any other opcode is illegal.
REQ-019 The FSM SHALL have two states, IDLE and MEM, and reset to IDLE.
REQ-020 IDLE -> MEM: ACC is valid and holds a LOAD or STORE, and mem_ack is low.
REQ-021 MEM -> IDLE: mem_ack is high.
REQ-022 mem_req SHALL equal ACC.valid AND (LOAD or STORE), combinationally from ACC, in both states.
REQ-023 A zero-wait ack (mem_ack high in the first request cycle) SHALL complete the access without entering MEM.
REQ-024 stall SHALL equal mem_req AND NOT mem_ack.
REQ-025 mem_ack SHALL be ignored while mem_req is low.
REQ-026 MemRW, mem_size and load_unsigned SHALL be decoded from ACC; they are don't-care while mem_req is low.
REQ-027 When stall is low, WB SHALL load ACC on each edge.
REQ-028 When stall is high, WB SHALL load a bubble (valid = 0), so a writeback is issued exactly once.
REQ-029 RegWEn SHALL be 1 only if WB is valid, its opcode is LOAD, JAL, JALR, LUI, AUIPC, OP or OP-IMM, and rd is not 0.
REQ-030 WBSel SHALL be 0 for LOAD, 2 for JAL/JALR, and 1 otherwise.
REQ-031 rd_wb SHALL equal WB.instr[11:7].
REQ-032 Total latency is 2 cycles from instr_acc accepted to RegWEn, plus one cycle per memory wait cycle.
REQ-033 An illegal opcode SHALL pass through as a bubble: no mem_req, no RegWEn.
REQ-034 stall_cnt SHALL increment on each cycle with stall high and saturate at 0xFFFF.

Reset
REQ-035 Reset SHALL clear ACC.valid and WB.valid to 0 and the FSM to IDLE.
REQ-036 Reset SHALL set stall_cnt to 0.
REQ-037 Output values after reset: stall 0, mem_req 0, RegWEn 0, WBSel 1, rd_wb 0.
REQ-038 Reset asserted mid-access SHALL abandon the request; mem_req is low on the next cycle.

Structure
REQ-039 Opcode constants, WBSel encodings and FSM state encodings SHALL live in the shared pipeline control package.
REQ-040 One sub-module, wb_decode, SHALL map {valid, instr} to {RegWEn, WBSel, rd_wb} combinationally.

Verification
REQ-041 ADD x5 with acc_valid high, no stall -> RegWEn 1, WBSel 1, rd_wb 5 two cycles later.
REQ-042 LW x7 with mem_ack low for 3 cycles, then high -> stall high 3 cycles, stall_cnt 3, one RegWEn pulse with WBSel 0, rd_wb 7.
REQ-043 SW with mem_ack high in the first request cycle -> MemRW 1, mem_size 2, no stall, RegWEn 0.
REQ-044 ADDI x0 then JAL x1 back-to-back -> first gives RegWEn 0; second gives RegWEn 1, WBSel 2, rd_wb 1.
REQ-045 LBU issued, rst high during the second wait cycle -> next cycle mem_req 0, stall 0, RegWEn 0, stall_cnt 0.
REQ-046 Opcode 1111111 with acc_valid high -> no mem_req, no RegWEn; mem_ack pulsed while idle -> no state change.

Source files
------------

// File: rtl/mem_wb_ctl_pkg.sv
// Shared pipeline control definitions: opcode classes, writeback select codes and FSM states.
package mem_wb_ctl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [1:0] WBSEL_MEM = 2'd0;
    localparam logic [1:0] WBSEL_ALU = 2'd1;
    localparam logic [1:0] WBSEL_PC4 = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEM  = 1'b1
    } state_t;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/mem_wb_ctl_wb_decode.sv
// Writeback-stage decode: turns the WB register contents into register-file controls.
import mem_wb_ctl_pkg::*;

module wb_decode (
    input  logic        valid,
    input  logic [11:0] instr,
    output logic        reg_wen,
    output logic [1:0]  wb_sel,
    output logic [4:0]  rd
);

    logic [6:0] opc;
    logic       writes_rd;

    assign opc = instr[6:0];
    assign rd  = instr[11:7];

    always_comb begin
        writes_rd = 1'b0;
        wb_sel    = WBSEL_ALU;
        case (opc)
            OPC_LOAD: begin
                writes_rd = 1'b1;
                wb_sel    = WBSEL_MEM;
            end
            OPC_JAL, OPC_JALR: begin
                writes_rd = 1'b1;
                wb_sel    = WBSEL_PC4;
            end
            OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM: writes_rd = 1'b1;
            default: writes_rd = 1'b0;
        endcase
    end

    // Writes to x0 are discarded, as are bubbles and illegal opcodes.
    assign reg_wen = valid && writes_rd && (rd != 5'd0);

endmodule

// File: rtl/mem_wb_ctl.sv
// Memory-access / writeback control: ACC and WB pipeline registers, data-memory
// handshake FSM, stall generation and a saturating stall-cycle counter.
import mem_wb_ctl_pkg::*;

module mem_wb_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_acc,
    input  logic        acc_valid,
    output logic        stall,
    output logic        mem_req,
    output logic        MemRW,
    output logic [1:0]  mem_size,
    output logic        load_unsigned,
    input  logic        mem_ack,
    output logic        RegWEn,
    output logic [1:0]  WBSel,
    output logic [4:0]  rd_wb,
    output logic [15:0] stall_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        acc_vld_p0;
    logic [31:0] acc_instr_p0;
    logic        wb_vld_p1;
    logic [31:0] wb_instr_p1;
    state_t      state;
    state_t      state_next;
    logic        is_load;
    logic        is_store;
    logic        unused_wb_hi;

    // ACC stage: memory access decode
    assign is_load       = (acc_instr_p0[6:0] == OPC_LOAD);
    assign is_store      = (acc_instr_p0[6:0] == OPC_STORE);
    assign mem_req       = acc_vld_p0 && is_mem_op(acc_instr_p0[6:0]);
    assign stall         = mem_req && !mem_ack;
    assign MemRW         = is_store;
    assign mem_size      = acc_instr_p0[13:12];
    assign load_unsigned = is_load && acc_instr_p0[14];

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (mem_req && !mem_ack) state_next = ST_MEM;
            ST_MEM:  if (mem_ack) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Instruction words are cleared too so rd_wb/WBSel read a defined value out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_vld_p0   <= 1'b0;
            acc_instr_p0 <= '0;
            wb_vld_p1    <= 1'b0;
            wb_instr_p1  <= '0;
            stall_cnt    <= '0;
        end else if (stall) begin
            wb_vld_p1    <= 1'b0;
            stall_cnt    <= sat_inc(stall_cnt);
        end else begin
            acc_vld_p0   <= acc_valid;
            acc_instr_p0 <= instr_acc;
            wb_vld_p1    <= acc_vld_p0;
            wb_instr_p1  <= acc_instr_p0;
        end
    end

    // WB stage: register-file controls
    wb_decode u_wb_decode (
        .valid   (wb_vld_p1),
        .instr   (wb_instr_p1[11:0]),
        .reg_wen (RegWEn),
        .wb_sel  (WBSel),
        .rd      (rd_wb)
    );

    assign unused_wb_hi = ^wb_instr_p1[31:12];

endmodule

// File: tb/tb_mem_wb_ctl.sv
// Self-checking bench for mem_wb_ctl: directed scenarios plus a randomized run
// against a cycle-level reference model of the ACC/WB slots.
module tb_mem_wb_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_acc;
    logic        acc_valid;
    logic        stall;
    logic        mem_req;
    logic        MemRW;
    logic [1:0]  mem_size;
    logic        load_unsigned;
    logic        mem_ack;
    logic        RegWEn;
    logic [1:0]  WBSel;
    logic [4:0]  rd_wb;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD_X5  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011};
    localparam logic [31:0] I_LW_X7   = {12'd8, 5'd1, 3'b010, 5'd7, 7'b0000011};
    localparam logic [31:0] I_SW      = {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'b0100011};
    localparam logic [31:0] I_ADDI_X0 = {12'd1, 5'd0, 3'b000, 5'd0, 7'b0010011};
    localparam logic [31:0] I_JAL_X1  = {20'd16, 5'd1, 7'b1101111};
    localparam logic [31:0] I_LBU_X3  = {12'd0, 5'd1, 3'b100, 5'd3, 7'b0000011};
    localparam logic [31:0] I_ILLEGAL = 32'h0000_007F;

    mem_wb_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .instr_acc     (instr_acc),
        .acc_valid     (acc_valid),
        .stall         (stall),
        .mem_req       (mem_req),
        .MemRW         (MemRW),
        .mem_size      (mem_size),
        .load_unsigned (load_unsigned),
        .mem_ack       (mem_ack),
        .RegWEn        (RegWEn),
        .WBSel         (WBSel),
        .rd_wb         (rd_wb),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; acc_valid = 1'b0; instr_acc = '0; mem_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Reference rules for the writeback controls.
    function automatic logic ref_wen(input logic v, input logic [31:0] i);
        logic [6:0] op;
        op = i[6:0];
        return v && (op inside {7'b0000011, 7'b1101111, 7'b1100111, 7'b0110111,
                                7'b0010111, 7'b0110011, 7'b0010011}) && (i[11:7] != 5'd0);
    endfunction

    function automatic logic [1:0] ref_sel(input logic [31:0] i);
        if (i[6:0] == 7'b0000011) return 2'd0;
        if (i[6:0] == 7'b1101111 || i[6:0] == 7'b1100111) return 2'd2;
        return 2'd1;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [10];
        logic [31:0] w;
        opcs = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                 7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011, 7'b1111111};
        w = $urandom;
        w[6:0] = opcs[$urandom_range(0, 9)];
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; acc_valid = 1'b1; instr_acc = I_ADD_X5; mem_ack = 1'b0;
        tick(); tick();
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
        checks++; if (RegWEn !== 1'b0) begin failures++; $display("FAIL reset_regwen got=%0b exp=0", RegWEn); end
        checks++; if (WBSel !== 2'd1) begin failures++; $display("FAIL reset_wbsel got=%0d exp=1", WBSel); end
        checks++; if (rd_wb !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", rd_wb); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        rst = 1'b0; acc_valid = 1'b0;
    endtask

    task automatic test_add();
        do_reset();
        acc_valid = 1'b1; instr_acc = I_ADD_X5;
        tick();
        acc_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL add_no_mem got=%0b%0b exp=00", mem_req, stall); end
        checks++; if (RegWEn !== 1'b0) begin failures++; $display("FAIL add_early_wen got=%0b exp=0", RegWEn); end
        tick();
        checks++; if (RegWEn !== 1'b1) begin failures++; $display("FAIL add_wen got=%0b exp=1", RegWEn); end
        checks++; if (WBSel !== 2'd1) begin failures++; $display("FAIL add_wbsel got=%0d exp=1", WBSel); end
        checks++; if (rd_wb !== 5'd5) begin failures++; $display("FAIL add_rd got=%0d exp=5", rd_wb); end
        tick();
        checks++; if (RegWEn !== 1'b0) begin failures++; $display("FAIL add_once got=%0b exp=0", RegWEn); end
    endtask

    task automatic test_load_wait();
        int wens;
        do_reset();
        acc_valid = 1'b1; instr_acc = I_LW_X7; mem_ack = 1'b0;
        tick();
        wens = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (stall !== 1'b1 || mem_req !== 1'b1) begin failures++; $display("FAIL lw_wait%0d got=%0b%0b exp=11", c, stall, mem_req); end
            if (RegWEn === 1'b1) wens++;
            tick();
        end
        checks++; if (MemRW !== 1'b0 || mem_size !== 2'd2 || load_unsigned !== 1'b0) begin failures++; $display("FAIL lw_decode got=%0b/%0d/%0b exp=0/2/0", MemRW, mem_size, load_unsigned); end
        mem_ack = 1'b1; acc_valid = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lw_ack_stall got=%0b exp=0", stall); end
        tick();
        mem_ack = 1'b0;
        checks++; if (RegWEn !== 1'b1 || WBSel !== 2'd0 || rd_wb !== 5'd7) begin failures++; $display("FAIL lw_wb got=%0b/%0d/%0d exp=1/0/7", RegWEn, WBSel, rd_wb); end
        checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL lw_cnt got=%0d exp=3", stall_cnt); end
        if (RegWEn === 1'b1) wens++;
        tick();
        if (RegWEn === 1'b1) wens++;
        checks++; if (wens != 1) begin failures++; $display("FAIL lw_pulses got=%0d exp=1", wens); end
    endtask

    task automatic test_store_zero_wait();
        do_reset();
        acc_valid = 1'b1; instr_acc = I_SW; mem_ack = 1'b1;
        tick();
        acc_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || stall !== 1'b0) begin failures++; $display("FAIL sw_req got=%0b%0b exp=10", mem_req, stall); end
        checks++; if (MemRW !== 1'b1 || mem_size !== 2'd2) begin failures++; $display("FAIL sw_decode got=%0b/%0d exp=1/2", MemRW, mem_size); end
        tick();
        mem_ack = 1'b0;
        checks++; if (RegWEn !== 1'b0) begin failures++; $display("FAIL sw_wen got=%0b exp=0", RegWEn); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL sw_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL sw_done got=%0b exp=0", mem_req); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        acc_valid = 1'b1; instr_acc = I_ADDI_X0;
        tick();
        instr_acc = I_JAL_X1;
        tick();
        acc_valid = 1'b0;
        checks++; if (RegWEn !== 1'b0) begin failures++; $display("FAIL b2b_addi_x0 got=%0b exp=0", RegWEn); end
        tick();
        checks++; if (RegWEn !== 1'b1 || WBSel !== 2'd2 || rd_wb !== 5'd1) begin failures++; $display("FAIL b2b_jal got=%0b/%0d/%0d exp=1/2/1", RegWEn, WBSel, rd_wb); end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        acc_valid = 1'b1; instr_acc = I_LBU_X3; mem_ack = 1'b0;
        tick();
        checks++; if (load_unsigned !== 1'b1 || mem_size !== 2'd0) begin failures++; $display("FAIL lbu_decode got=%0b/%0d exp=1/0", load_unsigned, mem_size); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; acc_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%0b%0b exp=00", mem_req, stall); end
        checks++; if (RegWEn !== 1'b0) begin failures++; $display("FAIL rstmid_wen got=%0b exp=0", RegWEn); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rstmid_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_illegal();
        do_reset();
        acc_valid = 1'b1; instr_acc = I_ILLEGAL;
        tick();
        acc_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL ill_req got=%0b exp=0", mem_req); end
        tick();
        checks++; if (RegWEn !== 1'b0) begin failures++; $display("FAIL ill_wen got=%0b exp=0", RegWEn); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (stall !== 1'b0 || mem_req !== 1'b0 || stall_cnt !== 16'd0) begin failures++; $display("FAIL idle_ack got=%0b%0b/%0d exp=00/0", stall, mem_req, stall_cnt); end
        acc_valid = 1'b1; instr_acc = I_ADD_X5;
        tick();
        acc_valid = 1'b0;
        tick();
        checks++; if (RegWEn !== 1'b1 || rd_wb !== 5'd5) begin failures++; $display("FAIL idle_after got=%0b/%0d exp=1/5", RegWEn, rd_wb); end
    endtask

    task automatic test_saturation();
        do_reset();
        acc_valid = 1'b1; instr_acc = I_LW_X7; mem_ack = 1'b0;
        tick();
        acc_valid = 1'b0;
        repeat (65540) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt got=%0h exp=ffff", stall_cnt); end
        checks++; if (stall !== 1'b1) begin failures++; $display("FAIL sat_stall got=%0b exp=1", stall); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checks++; if (stall_cnt !== 16'hFFFF || RegWEn !== 1'b1) begin failures++; $display("FAIL sat_hold got=%0h/%0b exp=ffff/1", stall_cnt, RegWEn); end
    endtask

    task automatic test_random();
        logic        m_acc_v, m_wb_v, held, em, es, ew;
        logic [31:0] m_acc_i, m_wb_i;
        int          m_cnt;
        do_reset();
        m_acc_v = 0; m_wb_v = 0; m_acc_i = '0; m_wb_i = '0; m_cnt = 0; held = 0;
        for (int c = 0; c < 2000; c++) begin
            em = m_acc_v && (m_acc_i[6:0] == 7'b0000011 || m_acc_i[6:0] == 7'b0100011);
            mem_ack = ($urandom_range(0, 2) == 0);
            if (!held) begin
                acc_valid = ($urandom_range(0, 3) != 0);
                instr_acc = rand_instr();
            end
            #1;
            es = em && !mem_ack;
            ew = ref_wen(m_wb_v, m_wb_i);
            checks++; if (mem_req !== em || stall !== es) begin failures++; $display("FAIL rnd_req c=%0d got=%0b%0b exp=%0b%0b", c, mem_req, stall, em, es); end
            if (em) begin
                checks++;
                if (MemRW !== (m_acc_i[6:0] == 7'b0100011) || mem_size !== m_acc_i[13:12] ||
                    load_unsigned !== (m_acc_i[6:0] == 7'b0000011 && m_acc_i[14])) begin
                    failures++; $display("FAIL rnd_decode c=%0d got=%0b/%0d/%0b instr=%08h", c, MemRW, mem_size, load_unsigned, m_acc_i);
                end
            end
            checks++; if (RegWEn !== ew) begin failures++; $display("FAIL rnd_wen c=%0d got=%0b exp=%0b", c, RegWEn, ew); end
            if (ew) begin
                checks++; if (WBSel !== ref_sel(m_wb_i) || rd_wb !== m_wb_i[11:7]) begin failures++; $display("FAIL rnd_wb c=%0d got=%0d/%0d exp=%0d/%0d", c, WBSel, rd_wb, ref_sel(m_wb_i), m_wb_i[11:7]); end
            end
            checks++; if (stall_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt); end
            if (es) begin
                m_wb_v = 1'b0;
                if (m_cnt < 65535) m_cnt++;
                held = 1'b1;
            end else begin
                m_wb_v = m_acc_v; m_wb_i = m_acc_i;
                m_acc_v = acc_valid; m_acc_i = instr_acc;
                held = 1'b0;
            end
            tick();
        end
        acc_valid = 1'b0; mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; acc_valid = 1'b0; instr_acc = '0; mem_ack = 1'b0;
        test_reset();
        test_add();
        test_load_wait();
        test_store_zero_wait();
        test_back_to_back();
        test_reset_mid_access();
        test_illegal();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
